// File: rtl/db_event_arbiter.sv
// Round-robin arbiter that merges debounced tick pulses into one valid/ready event stream.
// Optional sticky per-channel overflow flags are built when DB_EVENT_ARB_OVF_EN is defined.
module db_event_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int ID_W   = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] tick_i,
    input  logic              evt_ready_i,
`ifdef DB_EVENT_ARB_OVF_EN
    input  logic              ovf_clr_i,
    output logic [NUM_CH-1:0] ovf_o,
`endif
    output logic              evt_valid_o,
    output logic [ID_W-1:0]   evt_id_o,
    output logic [NUM_CH-1:0] evt_pend_o
);

    localparam int CW = ID_W + 1;

    typedef enum logic {IDLE, FULL} state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d, grant_oh;
    logic [ID_W-1:0]   last_q, last_d, id_q, id_d, rr_id;
    logic [CW-1:0]     cand;
    logic              rr_hit, slot_free;

    // Scan downward so the closest pending channel after last_q is the final one written.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = '0;
        cand   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = {1'b0, last_q} + CW'(i);
            if (cand >= CW'(NUM_CH)) cand = cand - CW'(NUM_CH);
            if (pend_q[cand[ID_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_d    = last_q;
        grant_oh  = '0;
        slot_free = (state_q == IDLE) || evt_ready_i;
        if (slot_free) begin
            if (rr_hit) begin
                state_d         = FULL;
                id_d            = rr_id;
                last_d          = rr_id;
                grant_oh[rr_id] = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
        // A new tick wins over a same-edge grant so it is never lost.
        pend_d = (pend_q & ~grant_oh) | tick_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign evt_valid_o = (state_q == FULL);
    assign evt_id_o    = id_q;
    assign evt_pend_o  = pend_q;

`ifdef DB_EVENT_ARB_OVF_EN
    logic [NUM_CH-1:0] ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_clr_i ? '0 : ovf_q) | (tick_i & pend_q & ~grant_oh);
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_db_event_arbiter.sv
// Scoreboard bench for db_event_arbiter: a set-based reference model predicts grants,
// a negedge monitor pops and compares each accepted event.
module tb_db_event_arbiter;

    localparam int NUM_CH = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] tick  = '0;
    logic              ready = 1'b0;
    logic              valid;
    logic [1:0]        id;
    logic [NUM_CH-1:0] pend;
`ifdef DB_EVENT_ARB_OVF_EN
    logic              ovf_clr = 1'b0;
    logic [NUM_CH-1:0] ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int seen[$];

    bit                m_full;
    int                m_id;
    int                m_last;
    logic [NUM_CH-1:0] m_pend;
    logic [NUM_CH-1:0] m_ovf;

    always #5 clk = ~clk;

    db_event_arbiter #(.NUM_CH(NUM_CH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tick_i      (tick),
        .evt_ready_i (ready),
`ifdef DB_EVENT_ARB_OVF_EN
        .ovf_clr_i   (ovf_clr),
        .ovf_o       (ovf),
`endif
        .evt_valid_o (valid),
        .evt_id_o    (id),
        .evt_pend_o  (pend)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 0;
        m_last = NUM_CH - 1;
        m_pend = '0;
        m_ovf  = '0;
        exp_q.delete();
    endtask

    // Reference: a slot either holds one event or is empty; the next winner is the
    // first pending channel found going upward (mod NUM_CH) from the previous winner.
    task automatic model_step();
        logic [NUM_CH-1:0] t;
        bit free;
        int g;
        t    = tick;
        free = !m_full || ready;
        g    = -1;
        if (free) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
`ifdef DB_EVENT_ARB_OVF_EN
        if (ovf_clr) m_ovf = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (t[n] && m_pend[n] && n != g) m_ovf[n] = 1'b1;
`endif
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_last    = g;
            m_id      = g;
            m_full    = 1'b1;
            exp_q.push_back(g);
        end else if (free) begin
            m_full = 1'b0;
        end
        m_pend = m_pend | t;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid", int'(valid), int'(m_full));
                chk("pend", int'(pend), int'(m_pend));
                if (valid) chk("id", int'(id), m_id);
`ifdef DB_EVENT_ARB_OVF_EN
                chk("ovf", int'(ovf), int'(m_ovf));
`endif
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_evt: got id %0d expected no event", id);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        chk("evt_id", int'(id), e);
                    end
                    seen.push_back(int'(id));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick  = '0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int e3[3];
        int e2[2];
        int n0, n3;

        // Reset values
        cyc(3);
        @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_id", int'(id), 0);
        chk("rst_pend", int'(pend), 0);
`ifdef DB_EVENT_ARB_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single tick on ch2: valid two cycles after the tick, for one cycle
        ready = 1'b1;
        tick  = 4'b0100;
        cyc(1);
        tick = '0;
        @(negedge clk);
        chk("lat_valid_k", int'(valid), 0);
        chk("lat_pend_k", int'(pend), 4);
        @(posedge clk); #2;
        @(negedge clk);
        chk("lat_valid_k1", int'(valid), 1);
        chk("lat_id_k1", int'(id), 2);
        @(posedge clk); #2;
        @(negedge clk);
        chk("lat_valid_k2", int'(valid), 0);
        chk("lat_pend_k2", int'(pend), 0);
        @(posedge clk); #2;

        // All four at once after reset: ids 0,1,2,3 back to back
        do_reset();
        seen.delete();
        ready = 1'b1;
        tick  = 4'b1111;
        cyc(1);
        tick = '0;
        cyc(5);
        chk("rr4_n", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("rr4_id", seen[i], i);
        @(negedge clk);
        chk("rr4_valid_after", int'(valid), 0);
        @(posedge clk); #2;

        // Stall 50 cycles holding ch1, ch0/ch3 tick meanwhile, then 1,3,0
        do_reset();
        seen.delete();
        ready = 1'b0;
        tick  = 4'b0010;
        cyc(1);
        tick = '0;
        cyc(1);
        tick = 4'b1001;
        cyc(1);
        tick = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!valid || id != 2'd1) chk("stall_hold", {31'd0, valid} * 16 + int'(id), 16 + 1);
            @(posedge clk); #2;
        end
        @(negedge clk);
        chk("stall_valid", int'(valid), 1);
        chk("stall_id", int'(id), 1);
        @(posedge clk); #2;
        ready = 1'b1;
        cyc(5);
        e3 = '{1, 3, 0};
        chk("stall_n", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("stall_order", seen[i], e3[i]);

        // Three ticks on ch1 while stalled merge into one event
        do_reset();
        seen.delete();
        ready = 1'b0;
        tick  = 4'b0001;
        cyc(1);
        tick = '0;
        cyc(1);
        tick = 4'b0010;
        cyc(3);
        tick = '0;
        cyc(1);
`ifdef DB_EVENT_ARB_OVF_EN
        @(negedge clk);
        chk("ovf_set", int'(ovf), 2);
        @(posedge clk); #2;
`endif
        ready = 1'b1;
        cyc(4);
        e2 = '{0, 1};
        chk("merge_n", seen.size(), 2);
        for (int i = 0; i < 2 && i < seen.size(); i++) chk("merge_order", seen[i], e2[i]);
`ifdef DB_EVENT_ARB_OVF_EN
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", int'(ovf), 0);
        @(posedge clk); #2;
`endif

        // Fairness: ch0 and ch3 tick every cycle
        do_reset();
        seen.delete();
        ready = 1'b1;
        tick  = 4'b1001;
        cyc(20);
        tick = '0;
        cyc(4);
        n0 = 0;
        n3 = 0;
        foreach (seen[i]) begin
            if (seen[i] == 0) n0++;
            if (seen[i] == 3) n3++;
        end
        chk("fair_total", n0 + n3, seen.size());
        chk("fair_balance", (n0 - n3 <= 1 && n3 - n0 <= 1) ? 1 : 0, 1);
        chk("fair_enough", (seen.size() >= 16) ? 1 : 0, 1);
        for (int i = 1; i < seen.size(); i++)
            if (seen[i] == seen[i-1]) chk("fair_alt", seen[i], 3 - seen[i-1]);

        // Reset pulse while valid with three channels pending
        do_reset();
        seen.delete();
        ready = 1'b0;
        tick  = 4'b1111;
        cyc(1);
        tick = '0;
        cyc(1);
        @(negedge clk);
        chk("pre_rst_valid", int'(valid), 1);
        chk("pre_rst_pend", int'(pend), 14);
        @(posedge clk); #2;
        rst_n = 1'b0;
        tick  = 4'b1111;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_pend", int'(pend), 0);
        chk("async_rst_id", int'(id), 0);
        cyc(1);
        rst_n = 1'b1;
        ready = 1'b1;
        tick  = 4'b0001;
        cyc(1);
        tick = '0;
        cyc(8);
        chk("post_rst_n", seen.size(), 1);
        if (seen.size() > 0) chk("post_rst_id", seen[0], 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
            ready = ($urandom_range(0, 3) != 0);
`ifdef DB_EVENT_ARB_OVF_EN
            ovf_clr = ($urandom_range(0, 31) == 0);
`endif
            cyc(1);
        end
        tick  = '0;
        ready = 1'b1;
`ifdef DB_EVENT_ARB_OVF_EN
        ovf_clr = 1'b0;
`endif
        cyc(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/db_event_arbiter.md
# db_event_arbiter

Collects one-cycle debounced tick pulses from `NUM_CH` debouncer instances and serialises them onto a single valid/ready event stream tagged with the channel id. It sits between the bank of debouncers (their `db_tick_o` outputs) and the event consumer (CPU interface or LED/UI sequencer). Arbitration is round-robin, so every pending channel is served. Ticks arriving while the consumer stalls are never lost except by merging on the same channel.

## Interface

- `NUM_CH`, default 4: number of tick inputs; legal range 2..16.
- `ID_W`, default `$clog2(NUM_CH)`: width of the channel id; derived, never overridden.

Ports:

- `clk_i`  input  1  system clock; all logic rises on posedge.
- `rst_ni`  input  1  reset, asynchronous and active-low; one clock domain only.
- `tick_i`  input  `NUM_CH`  per-channel one-cycle pulse from a debouncer's `db_tick_o`.
- `evt_valid_o`  output  1  event available on `evt_id_o`.
- `evt_ready_i`  input  1  consumer accepts the event this cycle when high together with `evt_valid_o`.
- `evt_id_o`  output  `ID_W`  channel index of the current event.
- `evt_pend_o`  output  `NUM_CH`  pending bits, registered status.
- `ovf_o`  output  `NUM_CH`  sticky per-channel overflow flags. Present only with `DB_EVENT_ARB_OVF_EN`.
- `ovf_clr_i`  input  1  synchronous clear of all `ovf_o` bits. Present only with `DB_EVENT_ARB_OVF_EN`.

## Operation

- Pending register `pend[NUM_CH]`:
  - Bit n sets on any edge where `tick_i[n]`=1.
  - Bit n clears on the edge it is granted.
  - If a grant and a new tick on the same channel fall on the same edge, the set wins and the bit stays 1.
- Output slot FSM, states:
  - IDLE: `evt_valid_o`=0.
  - FULL: `evt_valid_o`=1 and `evt_id_o` holds the event.
- Slot transitions:
  - The slot is free when in IDLE, or when in FULL with `evt_ready_i`=1.
  - Free and any `pend` bit set: grant one channel, load `evt_id_o`, clear its pend bit, go to (or stay in) FULL.
  - Free and no pend bit set: go to IDLE.
  - FULL and `evt_ready_i`=0: hold state; `evt_id_o` does not change.
- Round-robin arbitration:
  - Pointer `last` holds the most recently granted id.
  - The search starts at `last+1` and wraps modulo `NUM_CH`. The first set `pend` bit wins and `last` takes its id.
  - Non-power-of-two `NUM_CH`: ids ≥ `NUM_CH` are never produced; the wrap is explicit, not by bit truncation.
- Merging: a tick on channel n while `pend[n]`=1 produces no extra event (see Configuration).
- No combinational path from `evt_ready_i` or `tick_i` to any output; all outputs are registered.

## Timing

- Reset values: `evt_valid_o`=0, `evt_id_o`=0, `pend`=0, `evt_pend_o`=0, `ovf_o`=0, `last`=`NUM_CH`-1, so channel 0 has first priority.
- Latency:
  - Tick sampled at edge k sets pend at edge k.
  - With the slot free, the grant happens at edge k+1 and `evt_valid_o` is high after edge k+1.
  - Total: 2 cycles, tick to valid.
- Throughput: one event per cycle while `evt_ready_i` stays high and ticks are pending.
- Handshake:
  - Once `evt_valid_o` rises, it and `evt_id_o` stay stable until the acceptance edge.
  - Back-to-back events with no bubble when ready is held high.
- Reset mid-operation: deasserting `rst_ni` asynchronously drops all pending events, the slot and the overflow flags to their reset values. Ticks during reset are ignored.
- Recovery: the first tick sampled on the first edge after `rst_ni` rises is honoured.

## Configuration

- Macro `DB_EVENT_ARB_OVF_EN`.
- Defined:
  - `ovf_o` and `ovf_clr_i` exist.
  - `ovf_o[n]` sets when `tick_i[n]`=1 on an edge where `pend[n]`=1 and channel n is not being granted on that edge.
  - `ovf_clr_i` clears all flags. A clear and a new overflow on the same edge: the set wins.
- Undefined: both ports and all overflow logic are absent; merging is silent.

## Test plan

- Reset, then a single pulse on `tick_i[2]`, ready held 1 -> `evt_valid_o` high exactly 2 cycles after the tick with `evt_id_o`=2, for one cycle; `evt_pend_o` returns to 0.
- All four ticks in one cycle, ready 1 -> ids 0,1,2,3 on four consecutive cycles, valid low on the fifth.
- Ready held 0 for 50 cycles after an event on ch1, while ch0 and ch3 tick -> valid/id=1 stable for all 50 cycles; after ready rises, ids 1,3,0 in that order.
- Three ticks on ch1 while stalled, with `DB_EVENT_ARB_OVF_EN` defined -> exactly one ch1 event and `ovf_o`=4'b0010; `ovf_clr_i` pulse -> `ovf_o`=0.
- Fairness: ch0 ticks every cycle and ch3 ticks every cycle, ready 1 -> ids alternate 0,3,0,3 with no channel starved.
- `rst_ni` pulsed low for 1 cycle while valid=1 and 3 channels are pending -> all outputs zero immediately; no stale events appear after release.
